bcd_to_signed_binary: RTL and testbench

Sequential converter from a 4-digit packed BCD magnitude plus a sign bit to a 16-bit two's-complement binary number. It is the inverse of the binary-to-BCD and sign-magnitude stages that feed the 7-segment displays. It sits on the operand-entry side of the multiplier, between the digit-entry logic and the multiplier inputs. Conversion uses reverse double-dabble: shift right, then subtract 3 from any BCD digit that is ≥ 8. It runs one bit per clock, with a valid/ready handshake.

---
 rtl/bcd_to_signed_binary_if.sv | 24 ++
 rtl/bcd_to_signed_binary.sv | 138 +++++++++++++
 tb/tb_bcd_to_signed_binary.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_signed_binary_if.sv
// Request/response bundle between the digit-entry logic and the BCD-to-binary converter.
// The master drives a request; the slave reports progress and the converted result.
interface bcd_to_signed_binary_if #(
   parameter int DIGITS = 4,
   parameter int OUT_W  = 16
);
   logic                  valid;
   logic [4*DIGITS-1:0]   BCD_code;
   logic                  sign;
   logic                  busy;
   logic                  ready;
   logic [OUT_W-1:0]      number;
   logic                  error;

   modport master (
      output valid, BCD_code, sign,
      input  busy, ready, number, error
   );

   modport slave (
      input  valid, BCD_code, sign,
      output busy, ready, number, error
   );
endinterface

// File: rtl/bcd_to_signed_binary.sv
// Sequential sign + packed-BCD to two's-complement converter using reverse double-dabble,
// one magnitude bit per clock, with a valid/ready handshake carried on bcd_to_signed_binary_if.
module bcd_to_signed_binary #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14,
   parameter int OUT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   bcd_to_signed_binary_if.slave  bus
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      APPLY_SIGN,
      DONE
   } state_t;

   state_t                   r_state;
   state_t                   w_nextState;
   logic [BCD_W-1:0]         r_bcd;
   logic [BIN_W-1:0]         r_bin;
   logic                     r_sign;
   logic [CNT_W-1:0]         r_cnt;
   logic [OUT_W-1:0]         r_number;
   logic                     r_error;
   logic                     w_digitsOk;
   logic                     w_lastShift;
   logic [BCD_W+BIN_W-1:0]   w_shift;
   logic [BCD_W-1:0]         w_bcdNext;
   logic [BIN_W-1:0]         w_binNext;
   logic [OUT_W-1:0]         w_mag;
   logic [OUT_W-1:0]         w_signed;

   always_comb begin
      w_digitsOk = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (bus.BCD_code[4*d +: 4] > 4'd9) begin
            w_digitsOk = 1'b0;
         end
      end
   end

   // One reverse double-dabble step: shift right, then pull every digit that reached 8+ back by 3.
   always_comb begin
      w_shift   = {r_bcd, r_bin} >> 1;
      w_binNext = w_shift[BIN_W-1:0];
      w_bcdNext = w_shift[BCD_W+BIN_W-1:BIN_W];
      for (int d = 0; d < DIGITS; d++) begin
         if (w_shift[BIN_W + 4*d +: 4] >= 4'd8) begin
            w_bcdNext[4*d +: 4] = w_shift[BIN_W + 4*d +: 4] - 4'd3;
         end
      end
   end

   assign w_lastShift = (r_cnt == CNT_W'(BIN_W - 1));
   assign w_mag       = {{(OUT_W - BIN_W){1'b0}}, r_bin};
   assign w_signed    = r_sign ? (~w_mag + 1'b1) : w_mag;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (bus.valid) begin
               w_nextState = w_digitsOk ? CONVERT : DONE;
            end
         end
         CONVERT: begin
            if (w_lastShift) begin
               w_nextState = APPLY_SIGN;
            end
         end
         APPLY_SIGN: w_nextState = DONE;
         DONE:       w_nextState = IDLE;
         default:    w_nextState = IDLE;
      endcase
   end

   always_comb begin
      bus.busy  = (r_state != IDLE);
      bus.ready = (r_state == DONE);
   end

   assign bus.number = r_number;
   assign bus.error  = r_error;

   // number/error only change on the edge entering DONE so they stay stable through the ready cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bcd    <= '0;
         r_bin    <= '0;
         r_sign   <= 1'b0;
         r_cnt    <= '0;
         r_number <= '0;
         r_error  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.valid) begin
                  if (w_digitsOk) begin
                     r_bcd  <= bus.BCD_code;
                     r_bin  <= '0;
                     r_sign <= bus.sign;
                     r_cnt  <= '0;
                  end else begin
                     r_number <= '0;
                     r_error  <= 1'b1;
                  end
               end
            end
            CONVERT: begin
               r_bcd <= w_bcdNext;
               r_bin <= w_binNext;
               r_cnt <= r_cnt + 1'b1;
            end
            APPLY_SIGN: begin
               r_number <= w_signed;
               r_error  <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_signed_binary.sv
// Directed bench for bcd_to_signed_binary: expected results are queued when a request is
// accepted and popped when the converter raises ready.
module tb_bcd_to_signed_binary;

   typedef struct {
      logic [15:0] num;
      logic        err;
      int          lat;
   } exp_t;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   exp_t scoreboard[$];

   bcd_to_signed_binary_if #(.DIGITS(4), .OUT_W(16)) bus ();

   bcd_to_signed_binary #(.DIGITS(4), .BIN_W(14), .OUT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Decimal reference: weighs each nibble by its power of ten, independent of the shift algorithm.
   function automatic exp_t expectOf(input logic [15:0] bcd, input logic sgn);
      exp_t        e;
      int          mag;
      bit          bad;
      logic [3:0]  nib;
      mag = 0;
      bad = 0;
      for (int i = 3; i >= 0; i--) begin
         nib = bcd[4*i +: 4];
         if (nib > 4'd9) bad = 1;
         mag = mag * 10 + int'(nib);
      end
      if (bad) begin
         e.num = 16'h0000;
         e.err = 1'b1;
         e.lat = 0;
      end else begin
         e.num = sgn ? 16'(-mag) : 16'(mag);
         e.err = 1'b0;
         e.lat = 15;
      end
      return e;
   endfunction

   task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] bcd, input logic sgn, input bit track);
      @(negedge clk);
      bus.valid    = 1'b1;
      bus.BCD_code = bcd;
      bus.sign     = sgn;
      @(posedge clk);
      #1;
      bus.valid = 1'b0;
      checkVal("busyAfterAccept", 16'(bus.busy), 16'h0001);
      if (track) scoreboard.push_back(expectOf(bcd, sgn));
   endtask

   task automatic checkOutput(input bit inject);
      exp_t e;
      int   n;
      vectors++;
      assert (scoreboard.size() > 0) else begin
         miscompares++;
         $error("FAIL scoreboardEmpty: observed size 0 expected >0");
      end
      if (scoreboard.size() == 0) return;
      e = scoreboard.pop_front();
      n = 0;
      while (bus.ready !== 1'b1 && n < 40) begin
         if (inject && (n == 2 || n == 9)) begin
            bus.valid    = 1'b1;
            bus.BCD_code = 16'h1111;
            bus.sign     = 1'b0;
         end
         @(posedge clk);
         #1;
         bus.valid = 1'b0;
         n++;
      end
      checkVal("readyLatency", 16'(n), 16'(e.lat));
      checkVal("number", bus.number, e.num);
      checkVal("error", 16'(bus.error), 16'(e.err));
      checkVal("busyDuringReady", 16'(bus.busy), 16'h0001);
      @(posedge clk);
      #1;
      checkVal("readyOneCycle", 16'(bus.ready), 16'h0000);
      checkVal("busyAfterReady", 16'(bus.busy), 16'h0000);
   endtask

   task automatic countReady(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (bus.ready === 1'b1) cnt++;
      end
   endtask

   initial begin
      int         pulses;
      logic [15:0] rbcd;
      logic        rsgn;
      vectors      = 0;
      miscompares  = 0;
      rst          = 1'b0;
      bus.valid    = 1'b0;
      bus.BCD_code = 16'h0000;
      bus.sign     = 1'b0;

      #12;
      checkVal("resetBusy", 16'(bus.busy), 16'h0000);
      checkVal("resetReady", 16'(bus.ready), 16'h0000);
      checkVal("resetNumber", bus.number, 16'h0000);
      checkVal("resetError", 16'(bus.error), 16'h0000);
      @(negedge clk);
      rst = 1'b1;

      applyStimulus(16'h0000, 1'b0, 1'b1);
      checkOutput(1'b0);
      applyStimulus(16'h9999, 1'b0, 1'b1);
      checkOutput(1'b0);
      applyStimulus(16'h1234, 1'b1, 1'b1);
      checkOutput(1'b0);
      applyStimulus(16'h0000, 1'b1, 1'b1);
      checkOutput(1'b0);
      applyStimulus(16'h0001, 1'b1, 1'b1);
      checkOutput(1'b0);
      applyStimulus(16'h12A4, 1'b0, 1'b1);
      checkOutput(1'b0);
      applyStimulus(16'h0042, 1'b0, 1'b1);
      checkOutput(1'b0);

      for (int k = 0; k < 4; k++) begin
         for (int d = 0; d < 4; d++) rbcd[4*d +: 4] = 4'($urandom_range(0, 9));
         rsgn = 1'($urandom_range(0, 1));
         applyStimulus(rbcd, rsgn, 1'b1);
         checkOutput(1'b0);
      end

      applyStimulus(16'h5678, 1'b0, 1'b1);
      checkOutput(1'b1);
      countReady(20, pulses);
      checkVal("ignoredRequestReady", 16'(pulses), 16'h0000);

      applyStimulus(16'h4321, 1'b0, 1'b0);
      repeat (6) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst = 1'b0;
      #1;
      checkVal("asyncResetBusy", 16'(bus.busy), 16'h0000);
      checkVal("asyncResetReady", 16'(bus.ready), 16'h0000);
      checkVal("asyncResetNumber", bus.number, 16'h0000);
      checkVal("asyncResetError", 16'(bus.error), 16'h0000);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      countReady(20, pulses);
      checkVal("noReadyAfterReset", 16'(pulses), 16'h0000);

      applyStimulus(16'h0100, 1'b1, 1'b1);
      checkOutput(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
